matrix_capture: RTL and testbench

MATRIX_CAPTURE -- requirements
Module: matrix_capture

---
 rtl/matrix_capture_pkg.sv | 20 ++
 rtl/matrix_capture_if.sv | 27 ++
 rtl/matrix_capture_row_debounce.sv | 52 +++++
 rtl/matrix_capture.sv | 137 +++++++++++++
 tb/tb_matrix_capture.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/matrix_capture_pkg.sv
// Shared constants and types for the matrix capture path.
// The default grid size follows the display scanner's geometry.
package matrix_capture_pkg;

    localparam int DISP_ROWS  = 8;
    localparam int DISP_COLS  = 8;
    localparam int GS_DEF     = DISP_ROWS;
    localparam int STABLE_DEF = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } cap_state_e;

    // Index width that stays legal for a degenerate size of 1.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_capture_if.sv
// Scanner-side inputs and frame-side outputs of matrix_capture.
// The slave modport is the capture block; the master modport is its environment.
interface matrix_capture_if
    import matrix_capture_pkg::*;
#(
    parameter int GS = GS_DEF
);
    logic [GS-1:0]    row_val_i;
    logic [GS-1:0]    col_val_i;
    logic             frame_ready_i;
    logic             clr_err_i;
    logic [GS*GS-1:0] frame_o;
    logic             frame_valid_o;
    logic             overrun_o;
    logic             seq_err_o;
    logic [7:0]       frame_cnt_o;

    modport slave (
        input  row_val_i, col_val_i, frame_ready_i, clr_err_i,
        output frame_o, frame_valid_o, overrun_o, seq_err_o, frame_cnt_o
    );

    modport master (
        output row_val_i, col_val_i, frame_ready_i, clr_err_i,
        input  frame_o, frame_valid_o, overrun_o, seq_err_o, frame_cnt_o
    );
endinterface

// File: rtl/matrix_capture_row_debounce.sv
// Row strobe debouncer: a row is accepted once, when it has been seen
// STABLE consecutive cycles and the strobe is exactly one-hot.
module row_debounce
    import matrix_capture_pkg::*;
#(
    parameter int GS     = GS_DEF,
    parameter int STABLE = STABLE_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [GS-1:0]          row_val_i,
    output logic [idx_w(GS)-1:0]   row_idx_o,
    output logic                   accept_o
);
    localparam int IW = idx_w(GS);
    localparam int DW = idx_w(STABLE + 1);
    localparam logic [DW-1:0] STABLE_C = DW'(STABLE);
    localparam logic [DW-1:0] ONE_C    = DW'(1);

    logic [GS-1:0] samp_q, samp_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          same;

    always_comb begin
        samp_d    = row_val_i;
        same      = (row_val_i == samp_q);
        dwell_d   = dwell_q;
        row_idx_o = '0;
        if (!same) begin
            dwell_d = ONE_C;
        end else if (dwell_q != STABLE_C) begin
            dwell_d = dwell_q + ONE_C;
        end
        // A saturated dwell that keeps matching has already fired.
        accept_o = $onehot(row_val_i) && (dwell_d == STABLE_C)
                   && !(same && (dwell_q == STABLE_C));
        for (int r = 0; r < GS; r++) begin
            if (row_val_i[r]) row_idx_o = IW'(r);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            samp_q  <= '0;
            dwell_q <= '0;
        end else begin
            samp_q  <= samp_d;
            dwell_q <= dwell_d;
        end
    end

endmodule

// File: rtl/matrix_capture.sv
// Captures a row-scanned GSxGS pixel matrix into a shadow buffer and
// hands complete frames to a consumer over a valid/ready pair.
module matrix_capture
    import matrix_capture_pkg::*;
#(
    parameter int GS     = GS_DEF,
    parameter int STABLE = STABLE_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    matrix_capture_if.slave bus
);
    localparam int IW = idx_w(GS);
    localparam logic [IW-1:0] ONE_R  = IW'(1);
    localparam logic [IW-1:0] LAST_R = IW'(GS - 1);

    cap_state_e       state_q, state_d;
    logic [IW-1:0]    exp_q, exp_d;
    logic [GS*GS-1:0] shadow_q, shadow_d;
    logic [GS*GS-1:0] frame_q, frame_d;
    logic             fvalid_q, fvalid_d;
    logic             ovr_q, ovr_d;
    logic             seq_q, seq_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [IW-1:0]    row_idx;
    logic             accept;
    logic             complete, ovr_set, seq_set;

    row_debounce #(.GS(GS), .STABLE(STABLE)) u_deb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .row_val_i (bus.row_val_i),
        .row_idx_o (row_idx),
        .accept_o  (accept)
    );

    function automatic logic [GS*GS-1:0] put_row(input logic [GS*GS-1:0] buf_in,
                                                 input logic [IW-1:0]    idx,
                                                 input logic [GS-1:0]    col);
        logic [GS*GS-1:0] b;
        b = buf_in;
        for (int r = 0; r < GS; r++) begin
            if (IW'(r) == idx) b[r*GS +: GS] = col;
        end
        return b;
    endfunction

    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        shadow_d = shadow_q;
        frame_d  = frame_q;
        fvalid_d = fvalid_q;
        cnt_d    = cnt_q;
        complete = 1'b0;
        ovr_set  = 1'b0;
        seq_set  = 1'b0;

        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    if (row_idx == '0) begin
                        shadow_d = put_row('0, '0, bus.col_val_i);
                        exp_d    = ONE_R;
                        state_d  = COLLECT;
                    end
                end
                COLLECT: begin
                    if (row_idx == exp_q) begin
                        shadow_d = put_row(shadow_q, row_idx, bus.col_val_i);
                        if (row_idx == LAST_R) begin
                            complete = 1'b1;
                            exp_d    = '0;
                            state_d  = IDLE;
                        end else begin
                            exp_d = exp_q + ONE_R;
                        end
                    end else if (row_idx == '0) begin
                        seq_set  = 1'b1;
                        shadow_d = put_row('0, '0, bus.col_val_i);
                        exp_d    = ONE_R;
                    end else begin
                        seq_set = 1'b1;
                        exp_d   = '0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // shadow_d already carries the final row when a frame completes.
        if (complete) begin
            if (!fvalid_q || bus.frame_ready_i) begin
                frame_d  = shadow_d;
                fvalid_d = 1'b1;
                cnt_d    = cnt_q + 8'd1;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (fvalid_q && bus.frame_ready_i) begin
            fvalid_d = 1'b0;
        end

        ovr_d = ovr_set ? 1'b1 : (bus.clr_err_i ? 1'b0 : ovr_q);
        seq_d = seq_set ? 1'b1 : (bus.clr_err_i ? 1'b0 : seq_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            exp_q    <= '0;
            shadow_q <= '0;
            frame_q  <= '0;
            fvalid_q <= 1'b0;
            ovr_q    <= 1'b0;
            seq_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            shadow_q <= shadow_d;
            frame_q  <= frame_d;
            fvalid_q <= fvalid_d;
            ovr_q    <= ovr_d;
            seq_q    <= seq_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.frame_o       = frame_q;
    assign bus.frame_valid_o = fvalid_q;
    assign bus.overrun_o     = ovr_q;
    assign bus.seq_err_o     = seq_q;
    assign bus.frame_cnt_o   = cnt_q;

endmodule

// File: tb/tb_matrix_capture.sv
// Directed bench for matrix_capture with GS=8, STABLE=2; inputs change on
// the falling edge and outputs are sampled there too.
module tb_matrix_capture;
    import matrix_capture_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    matrix_capture_if #(.GS(8)) bus ();

    matrix_capture #(.GS(8), .STABLE(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] IMG1 = 64'h0000_0000_A500_0000;
    localparam logic [63:0] IMG2 = 64'h0102_0408_1020_4080;
    localparam logic [63:0] IMG3 = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] IMG4 = 64'h8000_0000_0000_0001;
    localparam logic [63:0] IMG5 = 64'h0011_2233_4455_6677;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic send_row(input int r, input logic [7:0] col, input int hold);
        bus.row_val_i    = '0;
        bus.row_val_i[r] = 1'b1;
        bus.col_val_i    = col;
        repeat (hold) @(negedge clk);
    endtask

    task automatic blank(input int n);
        bus.row_val_i = '0;
        bus.col_val_i = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [63:0] img, input int first, input int last, input int gap);
        for (int r = first; r <= last; r++) begin
            send_row(r, img[r*8 +: 8], 2);
            if (gap > 0) blank(gap);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [63:0] frm, input logic vld,
                            input logic ovr, input logic seq, input logic [7:0] cnt);
        chk({tag, ".frame"}, bus.frame_o, frm);
        chk({tag, ".valid"}, 64'(bus.frame_valid_o), 64'(vld));
        chk({tag, ".ovr"},   64'(bus.overrun_o), 64'(ovr));
        chk({tag, ".seq"},   64'(bus.seq_err_o), 64'(seq));
        chk({tag, ".cnt"},   64'(bus.frame_cnt_o), 64'(cnt));
    endtask

    task automatic pulse_clr();
        bus.clr_err_i = 1'b1;
        @(negedge clk);
        bus.clr_err_i = 1'b0;
    endtask

    initial begin
        bus.row_val_i     = '0;
        bus.col_val_i     = '0;
        bus.frame_ready_i = 1'b0;
        bus.clr_err_i     = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_outs("reset", 64'h0, 1'b0, 1'b0, 1'b0, 8'd0);
        rst = 1'b0;

        // First frame, with the latency of the last row checked edge by edge.
        scan(IMG1, 0, 6, 0);
        send_row(7, IMG1[63:56], 1);
        chk("lat.edge1.valid", 64'(bus.frame_valid_o), 64'h0);
        @(negedge clk);
        chk_outs("frame1", IMG1, 1'b1, 1'b0, 1'b0, 8'd1);

        // Second frame while the first is unconsumed is dropped.
        scan(IMG2, 0, 7, 0);
        chk_outs("overrun", IMG1, 1'b1, 1'b1, 1'b0, 8'd1);
        pulse_clr();
        chk("clr.ovr", 64'(bus.overrun_o), 64'h0);

        // Ready on the completion edge loads the new frame.
        scan(IMG2, 0, 6, 0);
        send_row(7, IMG2[63:56], 1);
        bus.frame_ready_i = 1'b1;
        @(negedge clk);
        chk_outs("handoff", IMG2, 1'b1, 1'b0, 1'b0, 8'd2);
        blank(1);
        chk("consume.valid", 64'(bus.frame_valid_o), 64'h0);
        chk("consume.frame", bus.frame_o, IMG2);
        bus.frame_ready_i = 1'b0;

        // Row 2 too short: row 3 is out of order.
        scan(IMG3, 0, 1, 0);
        send_row(2, IMG3[23:16], 1);
        send_row(3, IMG3[31:24], 2);
        chk("short.seq", 64'(bus.seq_err_o), 64'h1);
        scan(IMG3, 4, 7, 0);
        chk_outs("short.end", IMG2, 1'b0, 1'b0, 1'b1, 8'd2);
        pulse_clr();
        chk("clr.seq", 64'(bus.seq_err_o), 64'h0);

        // Multi-hot strobe and blank gaps are tolerated.
        scan(IMG3, 0, 2, 1);
        bus.row_val_i = 8'h03;
        bus.col_val_i = 8'hFF;
        repeat (5) @(negedge clk);
        scan(IMG3, 3, 7, 1);
        chk_outs("multihot", IMG3, 1'b1, 1'b0, 1'b0, 8'd3);
        bus.frame_ready_i = 1'b1;
        blank(1);
        bus.frame_ready_i = 1'b0;
        chk("consume2.valid", 64'(bus.frame_valid_o), 64'h0);

        // Row 0 mid-frame restarts capture and flags a sequence error.
        scan(ONES, 0, 2, 0);
        scan(IMG5, 0, 7, 0);
        chk_outs("restart", IMG5, 1'b1, 1'b0, 1'b1, 8'd4);

        // Reset mid-frame discards the partial rows and clears everything.
        scan(ONES, 0, 4, 0);
        bus.row_val_i = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_outs("midreset", 64'h0, 1'b0, 1'b0, 1'b0, 8'd0);
        scan(IMG4, 5, 7, 0);
        chk("partial.valid", 64'(bus.frame_valid_o), 64'h0);
        scan(IMG4, 0, 7, 0);
        chk_outs("postreset", IMG4, 1'b1, 1'b0, 1'b0, 8'd1);

        blank(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
